// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU command sequencer.
// Command/response layouts, opcode and shift-select codes, flag bit positions.
// FSM state encoding used by the sequencer top.
package alu_pkg;

  // ALU operation codes carried in the OP field
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // Shifter select codes carried in the OP_S field
  localparam logic [1:0] OPS_NONE = 2'b00;
  localparam logic [1:0] OPS_SR   = 2'b01;
  localparam logic [1:0] OPS_SL   = 2'b10;

  // Bit positions inside the 4-bit flag vector {Cero,Negativo,C_out,Overflow}
  localparam int FLAG_CERO = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_OVF  = 0;

  // 16-bit command word, MSB first
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [1:0] op_s;
    logic [1:0] shift_r;
    logic [1:0] shift_l;
  } alu_cmd_t;

  // 8-bit response word
  typedef struct packed {
    logic [3:0] result;
    logic [3:0] flags;
  } alu_rsp_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle for the ALU sequencer.
// master = command producer / response consumer, slave = the sequencer.
// Both channels use valid/ready; a beat moves when both are high at a clock edge.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic     cmd_valid;
  logic     cmd_ready;
  alu_cmd_t cmd_data;
  logic     rsp_valid;
  logic     rsp_ready;
  alu_rsp_t rsp_data;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Purpose: synchronous command FIFO with full/empty/occupancy outputs.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no bypass path.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;

  // Next-state for storage, pointers and occupancy; pointers wrap on power-of-2 depth
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: buffers ALU commands, drives registered operands, captures result+flags after a settle window.
// Latency: push at edge N into an empty FIFO -> pop at N+1 -> rsp_valid after edge N+1+SETTLE_CYC.
// Backpressure: cmd_ready low when the FIFO is full; response held until rsp_ready, one op in flight.
module alu_op_sequencer import alu_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         alu_op_s,
  output logic [1:0]         alu_shift_r,
  output logic [1:0]         alu_shift_l,
  input  logic [3:0]         alu_result,
  input  logic [3:0]         alu_flags,
  output logic [CNT_W-1:0]   ovf_count,
  output logic               busy
);

  localparam int              SC_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);
  localparam int              FCNT_W  = $clog2(FIFO_DEPTH) + 1;

  seq_state_t        state_q, state_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  alu_cmd_t          cmd_q, cmd_d;
  alu_rsp_t          rsp_q, rsp_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [15:0]       fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic              capture;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (bus.cmd_valid),
    .push_dat (bus.cmd_data),
    .pop_rdy  (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Sequencer: pop in IDLE, hold operands for the settle window, capture, then wait for the consumer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    rsp_vld_d = rsp_vld_q;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = alu_cmd_t'(fifo_head);
          cnt_d    = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SC_LAST) begin
          capture      = 1'b1;
          rsp_d.result = alu_result;
          rsp_d.flags  = alu_flags;
          rsp_vld_d    = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + SC_W'(1);
        end
      end
      RESP: begin
        // Operands stay on the ALU; the next pop waits for the following IDLE cycle
        if (bus.rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of captured results carrying the Overflow flag
  always_comb begin
    ovf_d = ovf_q;
    if (capture && alu_flags[FLAG_OVF] && (ovf_q != '1)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  // State registers; reset returns everything, including the operand outputs, to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_data  = rsp_q;

  assign alu_a       = cmd_q.a;
  assign alu_b       = cmd_q.b;
  assign alu_op      = cmd_q.op;
  assign alu_op_s    = cmd_q.op_s;
  assign alu_shift_r = cmd_q.shift_r;
  assign alu_shift_l = cmd_q.shift_l;

  assign ovf_count = ovf_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule
